// File: rtl/pipe_hazard_pkg.sv
// Shared types and constants for the pipeline hazard unit.
// Optional forwarding is enabled by defining PIPE_FWD_EN (see pipe_hazard_unit.sv).
package pipe_hazard_pkg;

    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned REG_AW_DEF = 4;
    // Scoreboard rd field is sized for the widest supported register file;
    // narrower addresses are zero-extended before storing and comparing.
    localparam int unsigned REG_AW_MAX = 8;
    // fwd_sel value meaning "take the register file read data"
    localparam int unsigned FWD_RF = 0;

    typedef struct packed {
        logic                  valid;
        logic                  wen;
        logic [REG_AW_MAX-1:0] rd;
        logic                  is_load;
    } sb_entry_t;

endpackage

// File: rtl/pipe_fwd_mux.sv
// Operand source select: register file data (sel 0) or the result bus of entry k (sel k).
module pipe_fwd_mux
    import pipe_hazard_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned N_STAGES = 3,
    parameter int unsigned SEL_W    = $clog2(N_STAGES + 1)
) (
    input  logic [SEL_W-1:0]           fwd_sel,
    input  logic [DATA_W-1:0]          rf_data,
    input  logic [N_STAGES*DATA_W-1:0] stage_result,
    output logic [DATA_W-1:0]          op_data
);

    // Pick the stage slice named by fwd_sel, falling back to the register file
    always_comb begin
        op_data = rf_data;
        for (int k = 1; k <= N_STAGES; k++) begin
            if (fwd_sel == SEL_W'(k)) begin
                op_data = stage_result[(k-1)*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_unit.sv
// RAW hazard detection, stall/flush generation and operand forwarding for the pipeline.
// Define PIPE_FWD_EN to forward results from in-flight stages; without it every
// dependence interlocks until the writer retires into the register file.
module pipe_hazard_unit
    import pipe_hazard_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned REG_AW   = REG_AW_DEF,
    parameter int unsigned N_STAGES = 3,
    localparam int unsigned SEL_W   = $clog2(N_STAGES + 1)
) (
    input  logic                       Clk,
    input  logic                       Rst,
    input  logic                       id_valid,
    input  logic [REG_AW-1:0]          id_rs1,
    input  logic [REG_AW-1:0]          id_rs2,
    input  logic                       id_rs1_used,
    input  logic                       id_rs2_used,
    input  logic [REG_AW-1:0]          id_rd,
    input  logic                       id_wen,
    input  logic                       id_is_load,
    input  logic                       ex_redirect,
    input  logic [DATA_W-1:0]          rf_data1,
    input  logic [DATA_W-1:0]          rf_data2,
    input  logic [N_STAGES*DATA_W-1:0] stage_result,
    output logic                       stall,
    output logic                       flush,
    output logic [SEL_W-1:0]           fwd_sel1,
    output logic [SEL_W-1:0]           fwd_sel2,
    output logic [DATA_W-1:0]          op_data1,
    output logic [DATA_W-1:0]          op_data2,
    output logic [DATA_W-1:0]          stall_cnt
);

    // sb_q[k] describes the instruction k cycles past decode
    sb_entry_t        sb_q [1:N_STAGES];
    sb_entry_t        entry_in;
    logic [SEL_W-1:0] win [2];
    logic             hz  [2];
    logic [REG_AW-1:0] rs   [2];
    logic              used [2];

    assign rs[0]   = id_rs1;
    assign rs[1]   = id_rs2;
    assign used[0] = id_rs1_used;
    assign used[1] = id_rs2_used;

    // Find the youngest matching writer per operand and decide if it blocks decode
    always_comb begin
        for (int n = 0; n < 2; n++) begin
            win[n] = '0;
            // Scan oldest to youngest so the youngest match is the one left standing
            for (int k = N_STAGES; k >= 1; k--) begin
                if (sb_q[k].valid && sb_q[k].wen && used[n] &&
                    sb_q[k].rd == REG_AW_MAX'(rs[n])) begin
                    win[n] = SEL_W'(k);
                end
            end
`ifdef PIPE_FWD_EN
            // Only a load still in entry 1 has no result on any bus yet
            hz[n] = (win[n] == SEL_W'(1)) && sb_q[1].is_load;
`else
            hz[n] = (win[n] != '0);
`endif
        end
    end

    // Hazard outputs; reset and redirect both override the interlock
    always_comb begin
        flush = !Rst && ex_redirect;
        stall = !Rst && !ex_redirect && id_valid && (hz[0] || hz[1]);
`ifdef PIPE_FWD_EN
        fwd_sel1 = Rst ? SEL_W'(FWD_RF) : win[0];
        fwd_sel2 = Rst ? SEL_W'(FWD_RF) : win[1];
`else
        fwd_sel1 = SEL_W'(FWD_RF);
        fwd_sel2 = SEL_W'(FWD_RF);
`endif
    end

    // Descriptor of the decode instruction, or a bubble when it does not advance
    always_comb begin
        entry_in = '0;
        if (id_valid && !stall && !flush) begin
            entry_in.valid   = 1'b1;
            entry_in.wen     = id_wen;
            entry_in.rd      = REG_AW_MAX'(id_rd);
            entry_in.is_load = id_is_load;
        end
    end

    // Shift the scoreboard one stage per cycle; the last entry retires
    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int k = 1; k <= N_STAGES; k++) begin
                sb_q[k] <= '0;
            end
        end else begin
            sb_q[1] <= entry_in;
            for (int k = 2; k <= N_STAGES; k++) begin
                sb_q[k] <= sb_q[k-1];
            end
        end
    end

    // Saturating count of stall cycles
    always_ff @(posedge Clk) begin
        if (Rst) begin
            stall_cnt <= '0;
        end else if (stall && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + DATA_W'(1);
        end
    end

    pipe_fwd_mux #(
        .DATA_W   (DATA_W),
        .N_STAGES (N_STAGES),
        .SEL_W    (SEL_W)
    ) u_mux1 (
        .fwd_sel      (fwd_sel1),
        .rf_data      (rf_data1),
        .stage_result (stage_result),
        .op_data      (op_data1)
    );

    pipe_fwd_mux #(
        .DATA_W   (DATA_W),
        .N_STAGES (N_STAGES),
        .SEL_W    (SEL_W)
    ) u_mux2 (
        .fwd_sel      (fwd_sel2),
        .rf_data      (rf_data2),
        .stage_result (stage_result),
        .op_data      (op_data2)
    );

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Bench for pipe_hazard_unit: directed vector table plus randomized traffic against
// an in-flight-writer list model. Follows PIPE_FWD_EN like the design.
module tb_pipe_hazard_unit;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam int NS = 3;
`ifdef PIPE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic             Clk;
    logic             Rst;
    logic             id_valid;
    logic [AW-1:0]    id_rs1, id_rs2, id_rd;
    logic             id_rs1_used, id_rs2_used, id_wen, id_is_load, ex_redirect;
    logic [DW-1:0]    rf_data1, rf_data2;
    logic [NS*DW-1:0] stage_result;
    logic             stall, flush;
    logic [1:0]       fwd_sel1, fwd_sel2;
    logic [DW-1:0]    op_data1, op_data2, stall_cnt;

    logic             s_stall, s_flush;
    logic [1:0]       s_sel1, s_sel2, s_op1, s_op2, s_cnt;
    logic [NS*2-1:0]  s_stage;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    pipe_hazard_unit #(.DATA_W(DW), .REG_AW(AW), .N_STAGES(NS)) u_dut (
        .Clk(Clk), .Rst(Rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
        .id_wen(id_wen), .id_is_load(id_is_load), .ex_redirect(ex_redirect),
        .rf_data1(rf_data1), .rf_data2(rf_data2), .stage_result(stage_result),
        .stall(stall), .flush(flush), .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
        .op_data1(op_data1), .op_data2(op_data2), .stall_cnt(stall_cnt)
    );

    // Narrow instance to exercise counter saturation
    assign s_stage = {stage_result[2*DW +: 2], stage_result[DW +: 2], stage_result[1:0]};
    pipe_hazard_unit #(.DATA_W(2), .REG_AW(AW), .N_STAGES(NS)) u_sat (
        .Clk(Clk), .Rst(Rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
        .id_wen(id_wen), .id_is_load(id_is_load), .ex_redirect(ex_redirect),
        .rf_data1(rf_data1[1:0]), .rf_data2(rf_data2[1:0]), .stage_result(s_stage),
        .stall(s_stall), .flush(s_flush), .fwd_sel1(s_sel1), .fwd_sel2(s_sel2),
        .op_data1(s_op1), .op_data2(s_op2), .stall_cnt(s_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model: list of writers with their age ----------------
    typedef struct {
        logic [AW-1:0] rd;
        bit            wen;
        bit            ld;
        int            age;
    } wr_t;

    wr_t     inflight[$];
    int      m_cnt;
    bit      m_stall, m_flush;
    int      m_sel1, m_sel2;
    logic [DW-1:0] m_op1, m_op2;

    task automatic find_writer(input logic [AW-1:0] rs, input bit used,
                               output int age, output bit ld);
        age = 0;
        ld  = 0;
        if (used) begin
            foreach (inflight[i]) begin
                if (inflight[i].wen && inflight[i].rd == rs &&
                    (age == 0 || inflight[i].age < age)) begin
                    age = inflight[i].age;
                    ld  = inflight[i].ld;
                end
            end
        end
    endtask

    task automatic model_eval();
        int a1, a2;
        bit l1, l2, h1, h2;
        find_writer(id_rs1, id_rs1_used, a1, l1);
        find_writer(id_rs2, id_rs2_used, a2, l2);
        h1 = FWD ? (a1 == 1 && l1) : (a1 != 0);
        h2 = FWD ? (a2 == 1 && l2) : (a2 != 0);
        if (Rst) begin
            m_flush = 0; m_stall = 0; m_sel1 = 0; m_sel2 = 0;
        end else begin
            m_flush = ex_redirect;
            m_stall = id_valid && !ex_redirect && (h1 || h2);
            m_sel1  = FWD ? a1 : 0;
            m_sel2  = FWD ? a2 : 0;
        end
        m_op1 = (m_sel1 == 0) ? rf_data1 : stage_result[(m_sel1-1)*DW +: DW];
        m_op2 = (m_sel2 == 0) ? rf_data2 : stage_result[(m_sel2-1)*DW +: DW];
    endtask

    task automatic model_update();
        wr_t nq[$];
        wr_t e;
        if (Rst) begin
            inflight.delete();
            m_cnt = 0;
        end else begin
            if (m_stall) m_cnt++;
            foreach (inflight[i]) begin
                e = inflight[i];
                e.age++;
                if (e.age <= NS) nq.push_back(e);
            end
            inflight = nq;
            if (id_valid && !m_stall && !m_flush) begin
                e.rd = id_rd; e.wen = id_wen; e.ld = id_is_load; e.age = 1;
                inflight.push_back(e);
            end
        end
    endtask

    // Compare every output with the model mid-cycle
    task automatic sample();
        @(negedge Clk);
        model_eval();
        check("m_stall", 32'(stall), 32'(m_stall));
        check("m_flush", 32'(flush), 32'(m_flush));
        check("m_sel1", 32'(fwd_sel1), 32'(m_sel1));
        check("m_sel2", 32'(fwd_sel2), 32'(m_sel2));
        check("m_op1", 32'(op_data1), 32'(m_op1));
        check("m_op2", 32'(op_data2), 32'(m_op2));
        check("m_cnt", 32'(stall_cnt), 32'(m_cnt > 65535 ? 65535 : m_cnt));
        check("m_sat_cnt", 32'(s_cnt), 32'(m_cnt > 3 ? 3 : m_cnt));
    endtask

    task automatic advance();
        @(posedge Clk);
        model_update();
        #1;
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        bit          rst, valid;
        logic [3:0]  rs1;
        bit          u1;
        logic [3:0]  rd;
        bit          wen, ld, redir;
        logic [15:0] s1, s2, s3;
        bit          e_stall, e_flush;
        logic [1:0]  e_sel1;
        logic [15:0] e_op1, e_cnt;
        logic [1:0]  e_sat;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit rst, bit valid, logic [3:0] rs1, bit u1, logic [3:0] rd,
                                bit wen, bit ld, bit redir,
                                logic [15:0] s1, logic [15:0] s2, logic [15:0] s3,
                                bit e_stall, bit e_flush, logic [1:0] e_sel1,
                                logic [15:0] e_op1, logic [15:0] e_cnt, logic [1:0] e_sat);
        vec_t v;
        v.rst = rst; v.valid = valid; v.rs1 = rs1; v.u1 = u1; v.rd = rd; v.wen = wen;
        v.ld = ld; v.redir = redir; v.s1 = s1; v.s2 = s2; v.s3 = s3;
        v.e_stall = e_stall; v.e_flush = e_flush; v.e_sel1 = e_sel1; v.e_op1 = e_op1;
        v.e_cnt = e_cnt; v.e_sat = e_sat;
        return v;
    endfunction

    localparam logic [15:0] RF = 16'hF00D;

    initial begin
        // rst valid rs1 u1 rd wen ld redir s1 s2 s3 | stall flush sel1 op1 cnt sat
        vecs.push_back(mk(1, 1, 3, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, RF, 0, 0));
        vecs.push_back(mk(1, 1, 3, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, RF, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, RF, 0, 0));
`ifdef PIPE_FWD_EN
        // R5 <- R3 : forwarded from entry 1
        vecs.push_back(mk(0, 1, 3, 1, 5, 1, 0, 0, 16'h00AA, 0, 0, 0, 0, 1, 16'h00AA, 0, 0));
        // load R2, then use: one stall, then entry 2
        vecs.push_back(mk(0, 1, 0, 0, 2, 1, 1, 0, 0, 0, 0, 0, 0, 0, RF, 0, 0));
        vecs.push_back(mk(0, 1, 2, 1, 6, 1, 0, 0, 16'h5555, 0, 0, 1, 0, 1, 16'h5555, 0, 0));
        vecs.push_back(mk(0, 1, 2, 1, 6, 1, 0, 0, 0, 16'h1234, 0, 0, 0, 2, 16'h1234, 1, 1));
        // R7 in entries 1 and 3: youngest wins
        vecs.push_back(mk(0, 1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, RF, 1, 1));
        vecs.push_back(mk(0, 1, 0, 0, 8, 1, 0, 0, 0, 0, 0, 0, 0, 0, RF, 1, 1));
        vecs.push_back(mk(0, 1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, RF, 1, 1));
        vecs.push_back(mk(0, 1, 7, 1, 9, 0, 0, 0, 16'h0001, 0, 16'h0003, 0, 0, 1, 16'h0001, 1, 1));
        // flush beats a load-use stall; entry 1 must become a bubble
        vecs.push_back(mk(0, 1, 0, 0, 2, 1, 1, 0, 0, 0, 0, 0, 0, 0, RF, 1, 1));
        vecs.push_back(mk(0, 1, 2, 1, 2, 1, 0, 1, 16'h0BAD, 0, 0, 0, 1, 1, 16'h0BAD, 1, 1));
        vecs.push_back(mk(0, 1, 2, 1, 6, 1, 0, 0, 0, 16'h1234, 0, 0, 0, 2, 16'h1234, 1, 1));
        // reset in the middle of a load-use hazard
        vecs.push_back(mk(0, 1, 0, 0, 4, 1, 1, 0, 0, 0, 0, 0, 0, 0, RF, 1, 1));
        vecs.push_back(mk(1, 1, 4, 1, 6, 1, 0, 0, 16'h4444, 0, 0, 0, 0, 0, RF, 1, 1));
        vecs.push_back(mk(0, 1, 4, 1, 6, 1, 0, 0, 16'h4444, 0, 0, 0, 0, 0, RF, 0, 0));
`else
        // R5 <- R3 interlocks for N_STAGES cycles, then reads the register file
        vecs.push_back(mk(0, 1, 3, 1, 5, 1, 0, 0, 16'h00AA, 0, 0, 1, 0, 0, RF, 0, 0));
        vecs.push_back(mk(0, 1, 3, 1, 5, 1, 0, 0, 0, 16'h00AA, 0, 1, 0, 0, RF, 1, 1));
        vecs.push_back(mk(0, 1, 3, 1, 5, 1, 0, 0, 0, 0, 16'h00AA, 1, 0, 0, RF, 2, 2));
        vecs.push_back(mk(0, 1, 3, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, RF, 3, 3));
        // keep stalling on R5: narrow counter saturates
        vecs.push_back(mk(0, 1, 5, 1, 6, 1, 0, 0, 0, 0, 0, 1, 0, 0, RF, 3, 3));
        vecs.push_back(mk(0, 1, 5, 1, 6, 1, 0, 0, 0, 0, 0, 1, 0, 0, RF, 4, 3));
        vecs.push_back(mk(0, 1, 5, 1, 6, 1, 0, 1, 0, 0, 0, 0, 1, 0, RF, 5, 3));
        vecs.push_back(mk(0, 1, 5, 1, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0, RF, 5, 3));
`endif

        Rst = 1; id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        id_rs1_used = 0; id_rs2_used = 0; id_wen = 0; id_is_load = 0; ex_redirect = 0;
        rf_data1 = RF; rf_data2 = 16'h2222; stage_result = '0;
        inflight.delete();
        m_cnt = 0;
        @(posedge Clk);
        #1;

        foreach (vecs[i]) begin
            Rst = vecs[i].rst; id_valid = vecs[i].valid;
            id_rs1 = vecs[i].rs1; id_rs1_used = vecs[i].u1;
            id_rs2 = 4'd4; id_rs2_used = 1'b0;
            id_rd = vecs[i].rd; id_wen = vecs[i].wen; id_is_load = vecs[i].ld;
            ex_redirect = vecs[i].redir;
            rf_data1 = RF; rf_data2 = 16'h2222;
            stage_result = {vecs[i].s3, vecs[i].s2, vecs[i].s1};
            sample();
            check($sformatf("tv%0d_stall", i), 32'(stall), 32'(vecs[i].e_stall));
            check($sformatf("tv%0d_flush", i), 32'(flush), 32'(vecs[i].e_flush));
            check($sformatf("tv%0d_sel1", i), 32'(fwd_sel1), 32'(vecs[i].e_sel1));
            check($sformatf("tv%0d_op1", i), 32'(op_data1), 32'(vecs[i].e_op1));
            check($sformatf("tv%0d_cnt", i), 32'(stall_cnt), 32'(vecs[i].e_cnt));
            check($sformatf("tv%0d_sat", i), 32'(s_cnt), 32'(vecs[i].e_sat));
            advance();
        end

        // Randomized traffic on a small register window to provoke hazards
        for (int c = 0; c < 400; c++) begin
            Rst          = ($urandom_range(0, 59) == 0);
            id_valid     = ($urandom_range(0, 3) != 0);
            id_rs1       = 4'($urandom_range(0, 3));
            id_rs2       = 4'($urandom_range(0, 3));
            id_rd        = 4'($urandom_range(0, 3));
            id_rs1_used  = ($urandom_range(0, 3) != 0);
            id_rs2_used  = ($urandom_range(0, 1) != 0);
            id_wen       = ($urandom_range(0, 3) != 0);
            id_is_load   = ($urandom_range(0, 2) == 0);
            ex_redirect  = ($urandom_range(0, 9) == 0);
            rf_data1     = 16'($urandom);
            rf_data2     = 16'($urandom);
            stage_result = {16'($urandom), 16'($urandom), 16'($urandom)};
            sample();
            advance();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
